// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: shift-mode select values
// and FSM state encodings.
package usr_pkg;

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SRA = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational one-bit shift: maps (value, mode, serialIn) to the shifted value
// and the bit that leaves the register. Reserved modes report validMode=0.
module shift_step_unit
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic [2:0]       mode,
   input  logic             serialIn,
   output logic [WIDTH-1:0] nextValue,
   output logic             outBit,
   output logic             validMode
);

   always_comb begin
      nextValue = value;
      outBit    = 1'b0;
      validMode = 1'b1;
      case (mode)
         MODE_SLL: begin
            nextValue = {value[WIDTH-2:0], serialIn};
            outBit    = value[WIDTH-1];
         end
         MODE_SRL: begin
            nextValue = {serialIn, value[WIDTH-1:1]};
            outBit    = value[0];
         end
         MODE_SRA: begin
            nextValue = {value[WIDTH-1], value[WIDTH-1:1]};
            outBit    = value[0];
         end
         MODE_ROL: begin
            nextValue = {value[WIDTH-2:0], value[WIDTH-1]};
            outBit    = value[WIDTH-1];
         end
         MODE_ROR: begin
            nextValue = {value[0], value[WIDTH-1:1]};
            outBit    = value[0];
         end
         default: validMode = 1'b0;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load, single-step shifts and counted
// burst shifts driven by a three-state IDLE/SHIFT/DONE controller.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             serialIn,
   input  logic             shiftEnable,
   input  logic             start,
   input  logic [CNT_W-1:0] shiftCount,
   output logic [WIDTH-1:0] dataOut,
   output logic             serialOut,
   output logic             busy,
   output logic             done,
   output logic [1:0]       fsmState
);

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] countReg;
   logic [2:0]       modeReg;
   logic [2:0]       stepMode;
   logic             doLoad;
   logic             doShift;
   logic             latchBurst;
   logic [WIDTH-1:0] stepValue;
   logic             stepBit;
   logic             stepValid;

   // Requests (load, start, shiftEnable) are level-sampled at each rising edge
   // and accepted only in IDLE, where load beats start beats shiftEnable; busy
   // acts as the not-ready indication and any request seen while busy or done
   // is dropped, never queued.
   always_comb begin
      stateNext  = state;
      doLoad     = 1'b0;
      doShift    = 1'b0;
      latchBurst = 1'b0;
      stepMode   = mode;
      case (state)
         ST_IDLE: begin
            if (load) begin
               doLoad = 1'b1;
            end else if (start) begin
               latchBurst = 1'b1;
               stateNext  = (shiftCount == '0) ? ST_DONE : ST_SHIFT;
            end else if (shiftEnable) begin
               doShift = 1'b1;
            end
         end
         ST_SHIFT: begin
            doShift  = 1'b1;
            stepMode = modeReg;
            if (countReg == CNT_W'(1)) stateNext = ST_DONE;
         end
         ST_DONE:  stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNext;
   end

   shift_step_unit #(.WIDTH(WIDTH)) stepUnit (
      .value     (dataOut),
      .mode      (stepMode),
      .serialIn  (serialIn),
      .nextValue (stepValue),
      .outBit    (stepBit),
      .validMode (stepValid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataOut   <= '0;
         serialOut <= 1'b0;
      end else if (doLoad) begin
         dataOut <= dataIn;
      end else if (doShift && stepValid) begin
         dataOut   <= stepValue;
         serialOut <= stepBit;
      end
   end

   // The mode is frozen at start so a burst is immune to mode changes mid-run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         countReg <= '0;
         modeReg  <= MODE_SLL;
      end else if (latchBurst) begin
         countReg <= shiftCount;
         modeReg  <= mode;
      end else if (state == ST_SHIFT) begin
         countReg <= countReg - CNT_W'(1);
      end
   end

   assign busy     = (state == ST_SHIFT);
   assign done     = (state == ST_DONE);
   assign fsmState = state;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8): vector table,
// directed burst/reset sequences and random bursts against an arithmetic model.
module tb_universal_shift_register;
   import usr_pkg::*;

   logic       clk;
   logic       reset;
   logic [2:0] mode;
   logic       load;
   logic [7:0] dataIn;
   logic       serialIn;
   logic       shiftEnable;
   logic       start;
   logic [3:0] shiftCount;
   logic [7:0] dataOut;
   logic       serialOut;
   logic       busy;
   logic       done;
   logic [1:0] fsmState;

   int nChecks = 0;
   int nFails  = 0;
   int mData   = 0;
   int mSer    = 0;
   logic [7:0] expQ[$];

   typedef struct {
      logic       ld;
      logic [7:0] din;
      logic       se;
      logic [2:0] md;
      logic       sin;
      logic [7:0] expData;
      logic       expSer;
   } vec_t;

   vec_t vecs[10];

   universal_shift_register #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .load        (load),
      .dataIn      (dataIn),
      .serialIn    (serialIn),
      .shiftEnable (shiftEnable),
      .start       (start),
      .shiftCount  (shiftCount),
      .dataOut     (dataOut),
      .serialOut   (serialOut),
      .busy        (busy),
      .done        (done),
      .fsmState    (fsmState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one shift by plain arithmetic on an integer image.
   task automatic modelStep(input logic [2:0] m, input logic sin);
      int s;
      s = int'(sin);
      case (m)
         3'd0: begin mSer = (mData >> 7) & 1; mData = ((mData << 1) | s) & 255; end
         3'd1: begin mSer = mData & 1; mData = (mData >> 1) | (s << 7); end
         3'd2: begin mSer = mData & 1; mData = (mData >> 1) | (mData & 128); end
         3'd3: begin mSer = (mData >> 7) & 1; mData = ((mData << 1) | (mData >> 7)) & 255; end
         3'd4: begin mSer = mData & 1; mData = (mData >> 1) | ((mData & 1) << 7); end
         default: ;
      endcase
   endtask

   task automatic clearInputs();
      mode = 3'd0; load = 1'b0; dataIn = 8'h00; serialIn = 1'b0;
      shiftEnable = 1'b0; start = 1'b0; shiftCount = 4'd0;
   endtask

   task automatic doLoad(input logic [7:0] v);
      load = 1'b1; dataIn = v;
      @(posedge clk); #1;
      load = 1'b0;
      mData = int'(v);
      check("loadData", dataOut, v);
   endtask

   task automatic doStep(input logic [2:0] m, input logic sin);
      shiftEnable = 1'b1; mode = m; serialIn = sin;
      @(posedge clk); #1;
      shiftEnable = 1'b0;
      modelStep(m, sin);
      check("stepData", dataOut, mData);
      check("stepSer", serialOut, mSer);
      check("stepDone", done, 0);
   endtask

   task automatic runBurst(input logic [2:0] m, input int n, input logic sin, input logic noise);
      expQ.delete();
      for (int i = 0; i < n; i++) begin
         modelStep(m, sin);
         expQ.push_back(mData[7:0]);
      end
      mode = m; shiftCount = n[3:0]; serialIn = sin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (noise) begin
         load = 1'b1; dataIn = 8'h55; shiftEnable = 1'b1;
         mode = 3'($urandom_range(0, 7));
      end
      check("burstBusyStart", busy, (n > 0));
      check("burstDoneStart", done, (n == 0));
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("burstData", dataOut, expQ.pop_front());
         check("burstBusy", busy, (i < n - 1));
         check("burstDone", done, (i == n - 1));
      end
      check("burstDataEnd", dataOut, mData);
      check("burstSer", serialOut, mSer);
      @(posedge clk); #1;
      load = 1'b0; shiftEnable = 1'b0;
      check("burstIdle", fsmState, ST_IDLE);
      check("burstDoneOnce", done, 0);
      check("burstIgnoreReq", dataOut, mData);
   endtask

   initial begin
      bit sawDone;
      clearInputs();
      reset = 1'b1;
      #3;
      check("rstData", dataOut, 0);
      check("rstSer", serialOut, 0);
      check("rstBusy", busy, 0);
      check("rstDone", done, 0);
      check("rstState", fsmState, ST_IDLE);
      @(negedge clk);
      reset = 1'b0;

      // Single-cycle requests in IDLE, including load-over-shiftEnable priority.
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 3'd0, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h4B, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 8'h25, 1'b1};
      vecs[3] = '{1'b1, 8'h90, 1'b0, 3'd0, 1'b0, 8'h90, 1'b1};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hC8, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 8'h91, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 8'hC8, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 1'b1, 3'd5, 1'b0, 8'hC8, 1'b1};
      vecs[8] = '{1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b0, 8'h80, 1'b1};
      for (int i = 0; i < 10; i++) begin
         load = vecs[i].ld; dataIn = vecs[i].din; shiftEnable = vecs[i].se;
         mode = vecs[i].md; serialIn = vecs[i].sin;
         @(posedge clk); #1;
         clearInputs();
         check("vecData", dataOut, vecs[i].expData);
         check("vecSer", serialOut, vecs[i].expSer);
         check("vecDone", done, 0);
         check("vecBusy", busy, 0);
      end
      load = 1'b1; dataIn = 8'h3C; shiftEnable = 1'b1; mode = 3'd0; serialIn = 1'b1;
      @(posedge clk); #1;
      clearInputs();
      check("loadPriority", dataOut, 8'h3C);
      mData = 8'h3C; mSer = 1;

      doLoad(8'hA5);
      runBurst(3'd0, 3, 1'b1, 1'b0);
      check("sllFinal", dataOut, 8'h2F);
      check("sllSer", serialOut, 1);

      doLoad(8'h90);
      runBurst(3'd2, 2, 1'b0, 1'b1);
      check("sraFinal", dataOut, 8'hE4);
      check("sraSer", serialOut, 0);

      doLoad(8'h3C);
      runBurst(3'd3, 8, 1'b0, 1'b1);
      check("rolFinal", dataOut, 8'h3C);

      doLoad(8'h6D);
      runBurst(3'd1, 0, 1'b1, 1'b0);
      check("zeroFinal", dataOut, 8'h6D);

      doLoad(8'hC3);
      runBurst(3'd6, 5, 1'b1, 1'b1);
      check("reservedFinal", dataOut, 8'hC3);

      doLoad(8'h81);
      runBurst(3'd4, 12, 1'b0, 1'b0);
      check("longRorFinal", dataOut, 8'h18);

      // Reset in the middle of a burst.
      doLoad(8'hF0);
      mode = 3'd0; shiftCount = 4'd10; serialIn = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("midBusyBefore", busy, 1);
      reset = 1'b1;
      #1;
      check("midRstData", dataOut, 0);
      check("midRstSer", serialOut, 0);
      check("midRstBusy", busy, 0);
      check("midRstDone", done, 0);
      check("midRstState", fsmState, ST_IDLE);
      @(negedge clk);
      load = 1'b1; dataIn = 8'h77;
      reset = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      check("postRstLoad", dataOut, 8'h77);
      mData = 8'h77; mSer = 0;
      sawDone = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) sawDone = 1'b1;
      end
      check("postRstNoDone", sawDone, 0);

      // Random single operations and bursts against the model.
      for (int r = 0; r < 30; r++) begin
         case ($urandom_range(0, 3))
            0: doLoad(8'($urandom_range(0, 255)));
            1: doStep(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            default: runBurst(3'($urandom_range(0, 7)), $urandom_range(0, 15),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, data register width (>= 2).
REQ-002 Derived constant: CNT_W, equal to clog2(WIDTH)+1, the width of the shift count.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  3  shift operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved (no data change).
REQ-006 load  input  1  parallel load request.
REQ-007 dataIn  input  WIDTH  parallel load data.
REQ-008 serialIn  input  1  bit shifted in by SLL (into LSB) and SRL (into MSB).
REQ-009 shiftEnable  input  1  single-step shift request.
REQ-010 start  input  1  burst shift request.
REQ-011 shiftCount  input  CNT_W  number of one-bit shifts in a burst.
REQ-012 dataOut  output  WIDTH  register contents.
REQ-013 serialOut  output  1  registered copy of the last bit shifted out (the rotated bit for ROL/ROR).
REQ-014 busy  output  1  high while a burst is shifting.
REQ-015 done  output  1  one-cycle pulse at burst completion.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-017 In IDLE, the SHALL apply request priority load > start > shiftEnable; only one request acts per cycle.
REQ-018 A load in IDLE SHALL set dataOut=dataIn at the next edge; serialOut is unchanged.
REQ-019 A shiftEnable in IDLE SHALL perform one shift in the current mode; done stays low.
REQ-020 A start in IDLE SHALL latch mode and shiftCount; the FSM goes to SHIFT if count>0, or to DONE if count=0 (no data change).
REQ-021 In SHIFT, each edge SHALL perform one shift in the latched mode and decrement the remaining count; when the remaining count reaches zero, the FSM goes to DONE.
REQ-022 Latency: for a start sampled at edge k with count N>=1, shifts SHALL occur at edges k+1..k+N, busy SHALL be high from after edge k through edge k+N, and done SHALL be high for the single cycle after edge k+N.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-024 load, start and shiftEnable SHALL be ignored in SHIFT and DONE.
REQ-025 Shift rules:
  - SLL: dataOut={dataOut[WIDTH-2:0],serialIn}.
  - SRL: dataOut={serialIn,dataOut[WIDTH-1:1]}.
  - SRA: replicate the MSB.
  - ROL/ROR: rotate by one; serialIn is ignored.
REQ-026 serialOut SHALL be the bit leaving the register end: MSB for SLL and ROL, LSB for SRL, SRA and ROR.
REQ-027 A reserved mode SHALL leave dataOut and serialOut unchanged; a burst in a reserved mode still runs N cycles and pulses done.
REQ-028 Counts above WIDTH SHALL be honoured literally: one bit per cycle, no clamping.

Reset
REQ-029 Asserting reset SHALL immediately force: dataOut=0, serialOut=0, busy=0, done=0, state=IDLE, count=0; this applies at any point, including mid-burst.
REQ-030 After reset deasserts, the first rising edge SHALL accept requests normally.

Structure
REQ-031 A shared package, usr_pkg, SHALL hold the mode encodings and the FSM state encodings.
REQ-032 One sub-module, shift_step_unit, SHALL be combinational and map (value, mode, serialIn) to (next value, out bit); the top-level module instantiates it once for both single-step and burst shifts.

Verification (WIDTH=8)
REQ-033 Reset mid-burst: assert reset during SHIFT -> dataOut=0x00, busy=0 and done=0 immediately, with no done pulse afterwards.
REQ-034 SLL burst: load 0xA5; start mode=000, shiftCount=3, serialIn=1 -> dataOut steps 0x4B, 0x97, 0x2F; serialOut=1; busy high 3 cycles; done for 1 cycle.
REQ-035 SRA burst: load 0x90; start mode=010, shiftCount=2 -> dataOut=0xE4, serialOut=0, done pulses once.
REQ-036 ROL burst: load 0x3C; start mode=011, shiftCount=8 -> dataOut=0x3C after 8 busy cycles.
REQ-037 Zero-count burst: start with shiftCount=0 -> done on the next cycle, dataOut unchanged, busy never high.
REQ-038 Ignored load: load 0x55 asserted while busy -> ignored.
REQ-039 Single step: load 0x01; shiftEnable with mode=100 -> dataOut=0x80, serialOut=1, done stays 0.
